// File: rtl/qsort_range_ctrl_if.sv
// Handshake bundle between the quicksort range sequencer and the partition stage.
// master: the sequencer. It issues (lo,hi) requests and receives the pivot index.
// slave : the partition stage.
interface qsort_range_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             part_req_valid;
  logic             part_req_ready;
  logic [IDX_W-1:0] part_lo;
  logic [IDX_W-1:0] part_hi;
  logic             part_res_valid;
  logic [IDX_W-1:0] part_res_idx;

  modport master (
    output part_req_valid,
    output part_lo,
    output part_hi,
    input  part_req_ready,
    input  part_res_valid,
    input  part_res_idx
  );

  modport slave (
    input  part_req_valid,
    input  part_lo,
    input  part_hi,
    output part_req_ready,
    output part_res_valid,
    output part_res_idx
  );
endinterface

// File: rtl/qsort_range_ctrl.sv
// Quicksort range sequencer.
// Keeps a LIFO of (lo,hi) sub-ranges. It issues one partition request per range
// and pushes the left and right sub-ranges that come back from each partition.
// The right range is pushed last, so it is popped first.
// The sort ends when the LIFO is empty. It also ends when a push is needed while
// the LIFO is full; that case sets the sticky overflow flag.
// Optional feature: define QSORT_STATS_EN to add the part_count output, which counts
// accepted requests and saturates at 255.
module qsort_range_ctrl #(
  parameter int ARR_WIDTH   = 4,
  parameter int IDX_W       = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  qsort_range_ctrl_if.master   part,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
`ifdef QSORT_STATS_EN
  ,
  output logic [7:0]           part_count
`endif
);

  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int EXT_W  = IDX_W + 1;
  localparam logic [SP_W:0]      DEPTH_EXT = (SP_W+1)'(STACK_DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(ARR_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH,
    ST_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] cur_lo_q, cur_hi_q, piv_q;
  logic [IDX_W-1:0] stk_lo [STACK_DEPTH];
  logic [IDX_W-1:0] stk_hi [STACK_DEPTH];

  logic [SIDX_W-1:0] top_idx, left_idx, right_idx;
  logic [IDX_W-1:0]  top_lo, top_hi;
  logic [SP_W:0]     sp_ext, right_slot;
  logic              need_left, need_right, left_fits, right_fits;
  logic              accept_start, pop_en, push_left, push_right, ovf_set;

  assign accept_start = (state_q == ST_IDLE) && start;

  // LIFO addressing and sub-range size tests.
  // The size tests use IDX_W+1 bits so that p-1 and p+1 cannot wrap.
  always_comb begin
    sp_ext     = {1'b0, sp_q};
    top_idx    = (sp_q == '0) ? '0 : SIDX_W'(sp_q - SP_W'(1));
    top_lo     = stk_lo[top_idx];
    top_hi     = stk_hi[top_idx];
    need_left  = EXT_W'(piv_q) > (EXT_W'(cur_lo_q) + EXT_W'(1));
    need_right = (EXT_W'(piv_q) + EXT_W'(1)) < EXT_W'(cur_hi_q);
    left_fits  = sp_ext < DEPTH_EXT;
    right_slot = sp_ext + {{SP_W{1'b0}}, (need_left && left_fits)};
    right_fits = right_slot < DEPTH_EXT;
    left_idx   = SIDX_W'(sp_q);
    right_idx  = SIDX_W'(right_slot);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and LIFO control strobes.
  always_comb begin
    state_d    = state_q;
    pop_en     = 1'b0;
    push_left  = 1'b0;
    push_right = 1'b0;
    ovf_set    = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_POP;
      ST_POP: begin
        if (sp_q == '0) begin
          state_d = ST_FIN;
        end else begin
          pop_en  = 1'b1;
          state_d = (top_lo >= top_hi) ? ST_POP : ST_ISSUE;
        end
      end
      ST_ISSUE: if (part.part_req_ready) state_d = ST_WAIT;
      ST_WAIT:  if (part.part_res_valid) state_d = ST_PUSH;
      ST_PUSH: begin
        push_left  = need_left && left_fits;
        push_right = need_right && right_fits;
        ovf_set    = (need_left && !left_fits) || (need_right && !right_fits);
        state_d    = ovf_set ? ST_FIN : ST_POP;
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stack pointer, current range, latched pivot, busy and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_q     <= '0;
      cur_lo_q <= '0;
      cur_hi_q <= '0;
      piv_q    <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept_start) begin
        sp_q     <= SP_W'(1);
        busy     <= 1'b1;
        overflow <= 1'b0;
      end else if (pop_en) begin
        sp_q     <= sp_q - SP_W'(1);
        cur_lo_q <= top_lo;
        cur_hi_q <= top_hi;
      end else if (state_q == ST_PUSH) begin
        sp_q <= sp_q + SP_W'(push_left) + SP_W'(push_right);
      end
      if ((state_q == ST_WAIT) && part.part_res_valid) piv_q <= part.part_res_idx;
      if (ovf_set) overflow <= 1'b1;
      if (state_q == ST_FIN) busy <= 1'b0;
    end
  end

  // LIFO storage. Entries are written before they are read, so the storage has no reset.
  always_ff @(posedge clock) begin
    if (accept_start) begin
      stk_lo[SIDX_W'(0)] <= '0;
      stk_hi[SIDX_W'(0)] <= LAST_IDX;
    end
    if (push_left) begin
      stk_lo[left_idx] <= cur_lo_q;
      stk_hi[left_idx] <= piv_q - IDX_W'(1);
    end
    if (push_right) begin
      stk_lo[right_idx] <= piv_q + IDX_W'(1);
      stk_hi[right_idx] <= cur_hi_q;
    end
  end

`ifdef QSORT_STATS_EN
  // Saturating count of accepted partition requests; cleared on start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                         part_count <= '0;
    else if (accept_start)                                part_count <= '0;
    else if ((state_q == ST_ISSUE) && part.part_req_ready
             && (part_count != 8'hFF))                    part_count <= part_count + 8'd1;
  end
`endif

  assign part.part_req_valid = (state_q == ST_ISSUE);
  assign part.part_lo        = cur_lo_q;
  assign part.part_hi        = cur_hi_q;
  assign done                = (state_q == ST_FIN);

endmodule

// File: tb/tb_qsort_range_ctrl.sv
// Directed bench for qsort_range_ctrl.
// dut_a uses the default configuration: 4 elements, 2-bit indices, 4-entry LIFO.
// dut_b is a 5-element, single-entry LIFO variant; its one run overflows the LIFO.
module tb_qsort_range_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, ovf_a;
  logic busy_b, done_b, ovf_b;
`ifdef QSORT_STATS_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  qsort_range_ctrl_if #(.IDX_W(2)) if_a ();
  qsort_range_ctrl_if #(.IDX_W(3)) if_b ();

  qsort_range_ctrl #(.ARR_WIDTH(4), .IDX_W(2), .STACK_DEPTH(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .part(if_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a)
`ifdef QSORT_STATS_EN
    , .part_count(cnt_a)
`endif
  );

  qsort_range_ctrl #(.ARR_WIDTH(5), .IDX_W(3), .STACK_DEPTH(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .part(if_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b)
`ifdef QSORT_STATS_EN
    , .part_count(cnt_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  int xfer_a = 0;

  // Count request transfers (valid & ready) seen at the clock edge.
  always @(posedge clock) if (if_a.part_req_valid && if_a.part_req_ready) xfer_a++;

  typedef struct {
    int lo;
    int hi;
    int p;
    bit first;
    bit last;
    int nreq;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid_a(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (if_a.part_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic serve_a(input int p);
    if_a.part_req_ready = 1'b1;
    tick();
    if_a.part_req_ready = 1'b0;
    chk("valid_drop", int'(if_a.part_req_valid), 0);
    tick();
    tick();
    if_a.part_res_valid = 1'b1;
    if_a.part_res_idx   = 2'(p);
    tick();
    if_a.part_res_valid = 1'b0;
  endtask

  task automatic wait_done_a(output bit ok, output bit extra);
    ok = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_a) begin
        ok = 1'b1;
        break;
      end
      if (if_a.part_req_valid) extra = 1'b1;
      tick();
    end
  endtask

  initial begin
    bit ok, extra;
    int base;

    if_a.part_req_ready = 1'b0;
    if_a.part_res_valid = 1'b0;
    if_a.part_res_idx   = '0;
    if_b.part_req_ready = 1'b0;
    if_b.part_res_valid = 1'b0;
    if_b.part_res_idx   = '0;

    // Expected request sequence for each scenario, with the pivot returned for each request.
    vecs[0] = '{0, 3, 3, 1'b1, 1'b0, 0};  // sorted input: pivot stays at hi
    vecs[1] = '{0, 2, 2, 1'b0, 1'b0, 0};
    vecs[2] = '{0, 1, 1, 1'b0, 1'b1, 3};
    vecs[3] = '{0, 3, 1, 1'b1, 1'b0, 0};  // middle pivot: left [0,0] is not pushed
    vecs[4] = '{2, 3, 3, 1'b0, 1'b1, 2};
    vecs[5] = '{0, 3, 0, 1'b1, 1'b0, 0};  // p=0: no left range, so p-1 is never formed
    vecs[6] = '{1, 3, 2, 1'b0, 1'b1, 2};
    vecs[7] = '{0, 3, 2, 1'b1, 1'b0, 0};  // only the left range [0,1] survives
    vecs[8] = '{0, 1, 0, 1'b0, 1'b1, 2};

    // Reset state
    tick();
    tick();
    chk("rst_valid_a", int'(if_a.part_req_valid), 0);
    chk("rst_busy_a",  int'(busy_a), 0);
    chk("rst_done_a",  int'(done_a), 0);
    chk("rst_ovf_a",   int'(ovf_a), 0);
    chk("rst_lo_a",    int'(if_a.part_lo), 0);
    chk("rst_hi_a",    int'(if_a.part_hi), 0);
    chk("rst_valid_b", int'(if_b.part_req_valid), 0);
    chk("rst_busy_b",  int'(busy_b), 0);
`ifdef QSORT_STATS_EN
    chk("rst_cnt_a",   int'(cnt_a), 0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Reset asserted while a request is outstanding
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("pre_rst_valid", int'(if_a.part_req_valid), 1);
    chk("pre_rst_busy",  int'(busy_a), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(if_a.part_req_valid), 0);
    chk("async_rst_busy",  int'(busy_a), 0);
    chk("async_rst_done",  int'(done_a), 0);
    chk("async_rst_ovf",   int'(ovf_a), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Table-driven scenarios
    base = 0;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].first) begin
        base = xfer_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("lat_pop_valid", int'(if_a.part_req_valid), 0);
        chk("busy_after_start", int'(busy_a), 1);
`ifdef QSORT_STATS_EN
        chk("cnt_cleared", int'(cnt_a), 0);
`endif
        tick();
        chk("lat_issue_valid", int'(if_a.part_req_valid), 1);
      end else begin
        wait_valid_a(ok);
        chk("req_seen", int'(ok), 1);
      end
      chk($sformatf("req_lo[%0d]", i), int'(if_a.part_lo), vecs[i].lo);
      chk($sformatf("req_hi[%0d]", i), int'(if_a.part_hi), vecs[i].hi);
      serve_a(vecs[i].p);
      if (vecs[i].last) begin
        wait_done_a(ok, extra);
        chk($sformatf("done_seen[%0d]", i), int'(ok), 1);
        chk($sformatf("no_extra_req[%0d]", i), int'(extra), 0);
        chk("busy_at_done", int'(busy_a), 1);
        chk("ovf_at_done", int'(ovf_a), 0);
        chk($sformatf("nreq[%0d]", i), xfer_a - base, vecs[i].nreq);
`ifdef QSORT_STATS_EN
        chk($sformatf("part_count[%0d]", i), int'(cnt_a), vecs[i].nreq);
`endif
        tick();
        chk("done_pulse_end", int'(done_a), 0);
        chk("busy_cleared", int'(busy_a), 0);
      end
    end

    // Back-pressure: request held stable; stray pivot result and start are ignored
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_valid_a(ok);
    chk("bp_req_seen", int'(ok), 1);
    base = xfer_a;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        if_a.part_res_valid = 1'b1;
        if_a.part_res_idx   = 2'd0;
      end
      tick();
      if_a.part_res_valid = 1'b0;
      chk("bp_valid_hold", int'(if_a.part_req_valid), 1);
      chk("bp_lo_hold", int'(if_a.part_lo), 0);
      chk("bp_hi_hold", int'(if_a.part_hi), 3);
    end
    chk("bp_no_xfer", xfer_a - base, 0);
    if_a.part_req_ready = 1'b1;
    tick();
    if_a.part_req_ready = 1'b0;
    chk("bp_valid_drop", int'(if_a.part_req_valid), 0);
    chk("bp_one_xfer", xfer_a - base, 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    if_a.part_res_valid = 1'b1;
    if_a.part_res_idx   = 2'd1;
    tick();
    if_a.part_res_valid = 1'b0;
    wait_valid_a(ok);
    chk("bp_req2_seen", int'(ok), 1);
    chk("bp_req2_lo", int'(if_a.part_lo), 2);
    chk("bp_req2_hi", int'(if_a.part_hi), 3);
    serve_a(2);
    wait_done_a(ok, extra);
    chk("bp_done_seen", int'(ok), 1);
    chk("bp_no_extra", int'(extra), 0);
    chk("bp_nreq", xfer_a - base, 2);
`ifdef QSORT_STATS_EN
    chk("bp_part_count", int'(cnt_a), 2);
`endif
    tick();

    // Overflow with a single-entry LIFO: (0,4) with p=2 needs both [0,1] and [3,4]
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    chk("ov_req_valid", int'(if_b.part_req_valid), 1);
    chk("ov_req_lo", int'(if_b.part_lo), 0);
    chk("ov_req_hi", int'(if_b.part_hi), 4);
    if_b.part_req_ready = 1'b1;
    tick();
    if_b.part_req_ready = 1'b0;
    tick();
    if_b.part_res_valid = 1'b1;
    if_b.part_res_idx   = 3'd2;
    tick();
    if_b.part_res_valid = 1'b0;
    ok = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_b) begin
        ok = 1'b1;
        break;
      end
      if (if_b.part_req_valid) extra = 1'b1;
      tick();
    end
    chk("ov_done_seen", int'(ok), 1);
    chk("ov_no_extra", int'(extra), 0);
    chk("ov_flag", int'(ovf_b), 1);
`ifdef QSORT_STATS_EN
    chk("ov_part_count", int'(cnt_b), 1);
`endif
    tick();
    chk("ov_sticky", int'(ovf_b), 1);
    chk("ov_done_end", int'(done_b), 0);
    chk("ov_busy_end", int'(busy_b), 0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("ov_cleared_on_start", int'(ovf_b), 0);
    tick();
    chk("ov_restart_valid", int'(if_b.part_req_valid), 1);
    chk("ov_restart_hi", int'(if_b.part_hi), 4);
    reset_n = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
